// File: rtl/rvco_freq_counter.sv
// Ring-oscillator frequency counter: resets the oscillator, lets it settle,
// counts synchronized rising edges over a 2^(8+gate_sel) cycle gate, and latches the count.
module rvco_freq_counter #(
  parameter int CNT_W      = 24,
  parameter int SETTLE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       osc_in,
  input  logic       start,
  input  logic [2:0] gate_sel,
  input  logic [1:0] byte_sel,
  output logic       osc_rst,
  output logic       busy,
  output logic       done,
  output logic [7:0] rd_byte
);

  typedef enum logic [2:0] {IDLE, RESET_OSC, SETTLE, GATE, LATCH} state_t;

  // Wide enough for the longest gate (32768-1) and SETTLE_CYC up to 65536.
  localparam int TMR_W = 16;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [TMR_W-1:0] tmr;
  logic [CNT_W-1:0] cnt;
  logic             cnt_ovf;
  logic [23:0]      result;
  logic             ovf;
  logic             valid;
  logic [2:0]       gs_cap;
  logic             s1, s2, s3;
  logic             edge_p;

  assign edge_p = s2 & ~s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tmr     <= '0;
      cnt     <= '0;
      cnt_ovf <= 1'b0;
      result  <= '0;
      ovf     <= 1'b0;
      valid   <= 1'b0;
      gs_cap  <= '0;
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      osc_rst <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      s1   <= osc_in;
      s2   <= s1;
      s3   <= s2;
      done <= 1'b0;
      if (!ena && state != IDLE) begin
        state   <= IDLE;
        busy    <= 1'b0;
        osc_rst <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && ena) begin
              state   <= RESET_OSC;
              gs_cap  <= gate_sel;
              tmr     <= TMR_W'(3);
              busy    <= 1'b1;
              osc_rst <= 1'b1;
            end
          end
          RESET_OSC: begin
            if (tmr == '0) begin
              state   <= SETTLE;
              tmr     <= TMR_W'(SETTLE_CYC - 1);
              osc_rst <= 1'b0;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          SETTLE: begin
            if (tmr == '0) begin
              state   <= GATE;
              tmr     <= (TMR_W'(256) << gs_cap) - TMR_W'(1);
              cnt     <= '0;
              cnt_ovf <= 1'b0;
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          GATE: begin
            if (edge_p) begin
              if (cnt == CNT_MAX) cnt_ovf <= 1'b1;
              else                cnt     <= cnt + CNT_W'(1);
            end
            if (tmr == '0) state <= LATCH;
            else           tmr   <= tmr - TMR_W'(1);
          end
          LATCH: begin
            result <= 24'(cnt);
            ovf    <= cnt_ovf;
            valid  <= 1'b1;
            done   <= 1'b1;
            // A held start chains straight into the next oscillator reset.
            if (start) begin
              state   <= RESET_OSC;
              gs_cap  <= gate_sel;
              tmr     <= TMR_W'(3);
              osc_rst <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
          default: begin
            state   <= IDLE;
            busy    <= 1'b0;
            osc_rst <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    rd_byte = '0;
    case (byte_sel)
      2'd0:    rd_byte = result[7:0];
      2'd1:    rd_byte = result[15:8];
      2'd2:    rd_byte = result[23:16];
      default: rd_byte = {busy, valid, ovf, 2'b00, gs_cap};
    endcase
  end

endmodule

// File: tb/tb_rvco_freq_counter.sv
// Randomized bench for rvco_freq_counter: expected counts come from the recorded
// osc_in history and the edge-timing rules; a narrow-counter instance checks saturation.
module tb_rvco_freq_counter;
  localparam int S = 16;

  logic       clk = 1'b0;
  logic       rst_n, ena, osc_in, start;
  logic [2:0] gate_sel;
  logic [1:0] byte_sel;
  logic       osc_rst, busy, done;
  logic [7:0] rd_byte;
  logic       osc_rst2, busy2, done2;
  logic [7:0] rd_byte2;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   osc_hist [0:131071];
  int   osc_mode = 0;
  int   osc_per = 4;
  logic osc_lvl = 1'b0;
  int   prev_res = 0;
  int   t0, lat, run, dones, r1, r2, st1, st2;

  rvco_freq_counter #(.CNT_W(24), .SETTLE_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start),
    .gate_sel(gate_sel), .byte_sel(byte_sel), .osc_rst(osc_rst), .busy(busy),
    .done(done), .rd_byte(rd_byte)
  );

  rvco_freq_counter #(.CNT_W(6), .SETTLE_CYC(S)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc_in), .start(start),
    .gate_sel(gate_sel), .byte_sel(byte_sel), .osc_rst(osc_rst2), .busy(busy2),
    .done(done2), .rd_byte(rd_byte2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    osc_hist[cyc] <= osc_in;
    cyc <= cyc + 1;
  end

  initial begin
    int ph;
    ph = 0;
    osc_in = 1'b0;
    forever begin
      @(negedge clk);
      case (osc_mode)
        0:       osc_in = osc_lvl;
        1:       osc_in = ((ph % osc_per) < (osc_per / 2));
        default: osc_in = 1'($urandom);
      endcase
      ph++;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Edge seen in gate cycle j reflects osc samples j-1 (new) and j-2 (old).
  function automatic int model_count(input int ts, input int n);
    int c;
    c = 0;
    for (int j = ts + 4 + S; j < ts + 4 + S + n; j++)
      if (osc_hist[j-1] && !osc_hist[j-2]) c++;
    return c;
  endfunction

  task automatic read_result(output int a1, output int a2, output int b1, output int b2);
    a1 = 0; a2 = 0;
    for (int b = 0; b < 3; b++) begin
      byte_sel = 2'(b);
      #1;
      a1 = a1 | (int'(rd_byte) << (8 * b));
      a2 = a2 | (int'(rd_byte2) << (8 * b));
    end
    byte_sel = 2'd3;
    #1;
    b1 = int'(rd_byte);
    b2 = int'(rd_byte2);
  endtask

  task automatic measure(input string tag, input logic [2:0] gs, input int fixed_exp, input bit poke);
    int ts, lt, orst, n, nlen, e2, o2, a1, a2, b1, b2;
    @(negedge clk);
    gate_sel = gs; start = 1'b1; ts = cyc;
    @(negedge clk);
    start = 1'b0; gate_sel = ~gs;
    orst = 0; lt = -1;
    for (int k = 0; k < 40000; k++) begin
      if (osc_rst) orst++;
      if (done) begin lt = cyc - 1 - ts; break; end
      start = (poke && k == 30);
      @(negedge clk);
    end
    start = 1'b0;
    nlen = 256 << gs;
    n = model_count(ts, nlen);
    e2 = (n > 63) ? 63 : n;
    o2 = (n > 63) ? 1 : 0;
    check({tag, "_latency"}, lt, 5 + S + nlen);
    check({tag, "_oscrst_cycles"}, orst, 4);
    check({tag, "_done_sat"}, int'(done2), 1);
    read_result(a1, a2, b1, b2);
    check({tag, "_result"}, a1, n);
    if (fixed_exp >= 0) check({tag, "_result_abs"}, a1, fixed_exp);
    check({tag, "_status"}, b1, 64 + int'(gs));
    check({tag, "_result_sat"}, a2, e2);
    check({tag, "_status_sat"}, b2, 64 + 32 * o2 + int'(gs));
    prev_res = a1;
    @(negedge clk);
    check({tag, "_done_width"}, int'(done), 0);
    check({tag, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; gate_sel = '0; byte_sel = '0;
    #3;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_oscrst", int'(osc_rst), 0);
    read_result(r1, r2, st1, st2);
    check("rst_result", r1, 0);
    check("rst_status", st1, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    osc_mode = 1; osc_per = 4;
    measure("div4", 3'd0, 64, 1'b0);

    osc_mode = 2;
    measure("poke", 3'd0, -1, 1'b1);

    // Held start: next oscillator reset follows LATCH directly.
    osc_mode = 1; osc_per = 4;
    @(negedge clk);
    gate_sel = 3'd0; start = 1'b1; t0 = cyc; lat = -1;
    for (int k = 0; k < 2000; k++) begin
      if (done) begin lat = cyc - 1 - t0; break; end
      @(negedge clk);
    end
    check("held_latency", lat, 5 + S + 256);
    check("held_oscrst_now", int'(osc_rst), 1);
    check("held_busy_now", int'(busy), 1);
    start = 1'b0;
    run = 1;
    repeat (4) begin
      @(negedge clk);
      if (osc_rst) run++;
    end
    check("held_oscrst_run", run, 4);
    ena = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    check("held_abort_busy", int'(busy), 0);
    prev_res = 64;

    // Abort mid-gate.
    @(negedge clk);
    gate_sel = 3'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_oscrst", int'(osc_rst), 0);
    dones = 0;
    repeat (300) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    read_result(r1, r2, st1, st2);
    check("abort_result", r1, prev_res);
    check("abort_status", st1, 64);
    ena = 1'b1;

    osc_mode = 0; osc_lvl = 1'b1;
    measure("static", 3'd3, 0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      osc_mode = int'($urandom_range(2, 1));
      osc_per = int'($urandom_range(10, 2));
      measure("rand", 3'($urandom_range(2, 0)), -1, 1'b0);
    end

    osc_mode = 1; osc_per = 8;
    measure("div8", 3'd7, 4096, 1'b0);

    // Asynchronous reset in SETTLE.
    @(negedge clk);
    gate_sel = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", int'(busy), 0);
    check("arst_oscrst", int'(osc_rst), 0);
    check("arst_done", int'(done), 0);
    read_result(r1, r2, st1, st2);
    check("arst_result", r1, 0);
    check("arst_status", st1, 0);
    check("arst_status_sat", st2, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
